// File: rtl/wb_write_queue_if.sv
// Bundle of the writeback queue's producer, register-file and forwarding signals.
// The master side (load/ALU producers, decode lookup) drives valids, data and lookup
// addresses; the slave side (the queue) drives readies, the RF write port and forwards.
interface wb_write_queue_if #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4
);
    logic                     ld_valid;
    logic [A_WIDTH-1:0]       ld_rd;
    logic [D_WIDTH-1:0]       ld_data;
    logic                     ld_ready;
    logic                     alu_valid;
    logic [A_WIDTH-1:0]       alu_rd;
    logic [D_WIDTH-1:0]       alu_data;
    logic                     alu_ready;
    logic                     WE3;
    logic [A_WIDTH-1:0]       A3;
    logic [D_WIDTH-1:0]       WD3;
    logic [A_WIDTH-1:0]       fa1;
    logic [A_WIDTH-1:0]       fa2;
    logic                     fwd1_hit;
    logic [D_WIDTH-1:0]       fwd1_data;
    logic                     fwd2_hit;
    logic [D_WIDTH-1:0]       fwd2_data;
    logic [$clog2(DEPTH):0]   pending;

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, fa1, fa2,
        input  ld_ready, alu_ready, WE3, A3, WD3,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, fa1, fa2,
        output ld_ready, alu_ready, WE3, A3, WD3,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, pending
    );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback write queue: merges load and ALU results into one in-order circular
// buffer and drains it into the register file write port (WE3/A3/WD3) at one
// write per cycle. Writes to x0 complete their handshake but are never queued.
// Optional feature: define WB_FWD_EN to enable the combinational forwarding
// lookup (fa1/fa2 against all queued entries); otherwise fwd* outputs are tied to 0.
module wb_write_queue #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 4
) (
    input logic            clk,
    input logic            rst,
    wb_write_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A_WIDTH-1:0] rdMem_q   [DEPTH];
    logic [D_WIDTH-1:0] dataMem_q [DEPTH];
    logic [PW-1:0]      rdPtr_q, rdPtr_d;
    logic [PW-1:0]      wrPtr_q, wrPtr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      aluSlot;
    logic [CW-1:0]      freeSlots;
    logic               popEn;
    logic               ldReady;
    logic               ldTake;
    logic               aluTake;

    // Slot accounting: the head frees its slot this cycle, so a non-empty queue offers one extra slot.
    always_comb begin
        popEn     = (count_q != '0) && !rst;
        freeSlots = CW'(DEPTH) - count_q + CW'(count_q != '0);
        ldReady   = (freeSlots >= CW'(1));
        ldTake    = bus.ld_valid && ldReady && (bus.ld_rd != '0);
        aluTake   = bus.alu_valid && (freeSlots >= (CW'(1) + CW'(ldTake))) && (bus.alu_rd != '0);
        bus.ld_ready  = ldReady;
        bus.alu_ready = (freeSlots >= (CW'(1) + CW'(ldTake)));
    end

    // Pointer and occupancy next state; the load is the older instruction so it takes the first slot.
    always_comb begin
        aluSlot = wrPtr_q + PW'(ldTake);
        wrPtr_d = wrPtr_q + PW'(ldTake) + PW'(aluTake);
        rdPtr_d = rdPtr_q + PW'(popEn);
        count_d = count_q + CW'(ldTake) + CW'(aluTake) - CW'(popEn);
    end

    // Pointer and count registers, cleared by reset so any queued writes are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while counted as valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ldTake) begin
                rdMem_q[wrPtr_q]   <= bus.ld_rd;
                dataMem_q[wrPtr_q] <= bus.ld_data;
            end
            if (aluTake) begin
                rdMem_q[aluSlot]   <= bus.alu_rd;
                dataMem_q[aluSlot] <= bus.alu_data;
            end
        end
    end

    // Register-file write port driven straight from the head entry; idle port reads as all zeros.
    always_comb begin
        bus.WE3     = popEn;
        bus.A3      = popEn ? rdMem_q[rdPtr_q]   : '0;
        bus.WD3     = popEn ? dataMem_q[rdPtr_q] : '0;
        bus.pending = count_q;
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] fwdIdx;

    // Forwarding lookup walks oldest to youngest so the youngest matching entry wins; the head counts too.
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd2_data = '0;
        fwdIdx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr_q + PW'(i);
            if (!rst && (CW'(i) < count_q)) begin
                if ((bus.fa1 != '0) && (rdMem_q[fwdIdx] == bus.fa1)) begin
                    bus.fwd1_hit  = 1'b1;
                    bus.fwd1_data = dataMem_q[fwdIdx];
                end
                if ((bus.fa2 != '0) && (rdMem_q[fwdIdx] == bus.fa2)) begin
                    bus.fwd2_hit  = 1'b1;
                    bus.fwd2_data = dataMem_q[fwdIdx];
                end
            end
        end
    end
`else
    // Forwarding disabled: decode always falls back to the register file.
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd2_data = '0;
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4). Forwarding
// expectations follow WB_FWD_EN: hits when defined, constant zeros otherwise.
module tb_wb_write_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_write_queue_if #(.A_WIDTH(5), .D_WIDTH(32), .DEPTH(4)) bus ();

    wb_write_queue #(.A_WIDTH(5), .D_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ldV, input logic [4:0] ldRd, input logic [31:0] ldD,
                                 input logic aluV, input logic [4:0] aluRd, input logic [31:0] aluD);
        bus.ld_valid  = ldV;
        bus.ld_rd     = ldRd;
        bus.ld_data   = ldD;
        bus.alu_valid = aluV;
        bus.alu_rd    = aluRd;
        bus.alu_data  = aluD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.fa1 = 5'd5;
        bus.fa2 = 5'd5;
        repeat (2) tick();
        rst = 1'b0;
        checks++; if (bus.pending !== 3'd0) begin failures++; $display("[TB] FAIL reset_pending: got %0d expected 0", bus.pending); end
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL reset_we3: got %0b expected 0", bus.WE3); end
        checks++; if (bus.A3 !== 5'd0) begin failures++; $display("[TB] FAIL reset_a3: got %0d expected 0", bus.A3); end
        checks++; if (bus.WD3 !== 32'd0) begin failures++; $display("[TB] FAIL reset_wd3: got %0h expected 0", bus.WD3); end
        checks++; if (bus.fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_fwd1_hit: got %0b expected 0", bus.fwd1_hit); end
        checks++; if (bus.fwd2_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_fwd2_data: got %0h expected 0", bus.fwd2_data); end
        bus.fa1 = 5'd0;
        bus.fa2 = 5'd0;
    endtask

    task automatic test_single_write();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_alu_ready: got %0b expected 1", bus.alu_ready); end
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL single_no_bypass: got %0b expected 0", bus.WE3); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("[TB] FAIL single_we3: got %0b expected 1", bus.WE3); end
        checks++; if (bus.A3 !== 5'd5) begin failures++; $display("[TB] FAIL single_a3: got %0d expected 5", bus.A3); end
        checks++; if (bus.WD3 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_wd3: got %0h expected deadbeef", bus.WD3); end
        checks++; if (bus.pending !== 3'd1) begin failures++; $display("[TB] FAIL single_pending: got %0d expected 1", bus.pending); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL single_we3_done: got %0b expected 0", bus.WE3); end
        checks++; if (bus.pending !== 3'd0) begin failures++; $display("[TB] FAIL single_pending_done: got %0d expected 0", bus.pending); end
    endtask

    task automatic test_dual_push();
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL dual_ld_ready: got %0b expected 1", bus.ld_ready); end
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL dual_alu_ready: got %0b expected 1", bus.alu_ready); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.pending !== 3'd2) begin failures++; $display("[TB] FAIL dual_pending: got %0d expected 2", bus.pending); end
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd3 || bus.WD3 !== 32'h11) begin failures++; $display("[TB] FAIL dual_first: got we=%0b a=%0d d=%0h expected we=1 a=3 d=11", bus.WE3, bus.A3, bus.WD3); end
        tick();
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd4 || bus.WD3 !== 32'h22) begin failures++; $display("[TB] FAIL dual_second: got we=%0b a=%0d d=%0h expected we=1 a=4 d=22", bus.WE3, bus.A3, bus.WD3); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL dual_done: got %0b expected 0", bus.WE3); end
    endtask

    task automatic test_x0_drop();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("[TB] FAIL x0_alu_ready: got %0b expected 1", bus.alu_ready); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.pending !== 3'd0) begin failures++; $display("[TB] FAIL x0_pending: got %0d expected 0", bus.pending); end
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL x0_we3: got %0b expected 0", bus.WE3); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL x0_we3_later: got %0b expected 0", bus.WE3); end
    endtask

    task automatic test_full();
        logic [4:0]  ldRdT   [9] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  aluRdT  [9] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic        aluRdyT [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        expWeT  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  expA3T  [9] = '{5'd0, 5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd0};
        logic [31:0] expWdT  [9] = '{32'h0, 32'h100, 32'h200, 32'h101, 32'h201, 32'h102, 32'h202, 32'h103, 32'h0};
        logic [2:0]  expPendT[9] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int c = 0; c < 9; c++) begin
            if (c < 4) applyStimulus(1'b1, ldRdT[c], 32'h100 + c, 1'b1, aluRdT[c], 32'h200 + c);
            else       applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checks++; if (bus.pending !== expPendT[c]) begin failures++; $display("[TB] FAIL full_pending[%0d]: got %0d expected %0d", c, bus.pending, expPendT[c]); end
            checks++; if (bus.WE3 !== expWeT[c] || bus.A3 !== expA3T[c] || bus.WD3 !== expWdT[c]) begin failures++; $display("[TB] FAIL full_write[%0d]: got we=%0b a=%0d d=%0h expected we=%0b a=%0d d=%0h", c, bus.WE3, bus.A3, bus.WD3, expWeT[c], expA3T[c], expWdT[c]); end
            if (c < 4) begin
                checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ld_ready[%0d]: got %0b expected 1", c, bus.ld_ready); end
                checks++; if (bus.alu_ready !== aluRdyT[c]) begin failures++; $display("[TB] FAIL full_alu_ready[%0d]: got %0b expected %0b", c, bus.alu_ready, aluRdyT[c]); end
            end
            tick();
        end
    endtask

    task automatic test_forwarding();
        applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        bus.fa1 = 5'd7;
        bus.fa2 = 5'd0;
        checks++; if (bus.fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd_empty_hit: got %0b expected 0", bus.fwd1_hit); end
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.fwd1_hit !== FWD) begin failures++; $display("[TB] FAIL fwd1_hit: got %0b expected %0b", bus.fwd1_hit, FWD); end
        checks++; if (bus.fwd1_data !== (FWD ? 32'hB : 32'h0)) begin failures++; $display("[TB] FAIL fwd1_youngest: got %0h expected %0h", bus.fwd1_data, (FWD ? 32'hB : 32'h0)); end
        checks++; if (bus.fwd2_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd2_x0: got %0b expected 0", bus.fwd2_hit); end
        checks++; if (bus.WE3 !== 1'b1 || bus.A3 !== 5'd7 || bus.WD3 !== 32'hA) begin failures++; $display("[TB] FAIL fwd_write_a: got we=%0b a=%0d d=%0h expected we=1 a=7 d=a", bus.WE3, bus.A3, bus.WD3); end
        tick();
        bus.fa2 = 5'd7;
        checks++; if (bus.fwd2_hit !== FWD) begin failures++; $display("[TB] FAIL fwd2_head_hit: got %0b expected %0b", bus.fwd2_hit, FWD); end
        checks++; if (bus.fwd2_data !== (FWD ? 32'hB : 32'h0)) begin failures++; $display("[TB] FAIL fwd2_head_data: got %0h expected %0h", bus.fwd2_data, (FWD ? 32'hB : 32'h0)); end
        tick();
        checks++; if (bus.fwd1_hit !== 1'b0) begin failures++; $display("[TB] FAIL fwd_drained_hit: got %0b expected 0", bus.fwd1_hit); end
        bus.fa1 = 5'd0;
        bus.fa2 = 5'd0;
    endtask

    task automatic test_reset_midrun();
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.pending !== 3'd3) begin failures++; $display("[TB] FAIL midrun_pending_before: got %0d expected 3", bus.pending); end
        rst = 1'b1;
        #1;
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL midrun_we3_in_reset: got %0b expected 0", bus.WE3); end
        tick();
        rst = 1'b0;
        checks++; if (bus.pending !== 3'd0) begin failures++; $display("[TB] FAIL midrun_pending_after: got %0d expected 0", bus.pending); end
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL midrun_we3_after: got %0b expected 0", bus.WE3); end
        tick();
        checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("[TB] FAIL midrun_we3_later: got %0b expected 0", bus.WE3); end
    endtask

    // Runs every scenario in order, then reports the totals.
    initial begin
        test_reset();
        test_single_write();
        test_dual_push();
        test_x0_drop();
        test_full();
        test_forwarding();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
